// File: rtl/char_rom_arbiter_pkg.sv
// Shared constants and helpers for the character-ROM arbiter slice.
// Holds field widths, default parameters and the blanking threshold.
package char_rom_pkg;

  localparam int unsigned CHAR_W          = 7;
  localparam int unsigned PIX_W           = 6;
  localparam int unsigned ROM_AW          = 13;
  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_ROM_LATENCY = 1;

  localparam logic [CHAR_W-1:0] BLANK_THRESH = 7'h20;

  // Index width that stays legal for a single requester.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/char_rom_arbiter_if.sv
// Requester/ROM bus of the character-ROM arbiter.
// slave: the arbiter side; master: requesters plus ROM.
interface char_rom_arbiter_if
  import char_rom_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) ();

  localparam int unsigned IdW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        Req;
  logic [CHAR_W*NUM_REQ-1:0] Caracter;
  logic [PIX_W*NUM_REQ-1:0]  Address;
  logic [NUM_REQ-1:0]        Gnt;
  logic [ROM_AW-1:0]         Rom_Address;
  logic                      Rom_Q;
  logic                      Data;
  logic                      Data_Valid;
  logic [IdW-1:0]            Data_Id;

  modport slave (
    input  Req, Caracter, Address, Rom_Q,
    output Gnt, Rom_Address, Data, Data_Valid, Data_Id
  );

  modport master (
    output Req, Caracter, Address, Rom_Q,
    input  Gnt, Rom_Address, Data, Data_Valid, Data_Id
  );

endinterface

// File: rtl/char_rom_arbiter_rr_sel.sv
// Combinational round-robin pick: first active request after index last,
// ascending with wrap-around.
module rr_sel
  import char_rom_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IdW    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IdW-1:0]     idx,
  output logic               valid
);

  always_comb begin
    logic [IdW-1:0] cand;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    // k = NUM_REQ revisits last itself, so a lone requester wins every cycle.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdW'((32'(last) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/char_rom_arbiter.sv
// Round-robin arbiter sharing one font ROM among NUM_REQ text windows.
// Optional CHAR_ROM_ARB_BLANK_EN forces Data=0 for control codes below 7'h20.
module char_rom_arbiter
  import char_rom_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned ROM_LATENCY = DEF_ROM_LATENCY
) (
  input logic               NCLK,
  input logic               RST,
  char_rom_arbiter_if.slave bus
);

  localparam int unsigned IdW = id_width(NUM_REQ);

  typedef struct packed {
    logic           valid;
    logic           blank;
    logic [IdW-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0] sel_gnt;
  logic [IdW-1:0]     sel_idx;
  logic               sel_valid;
  logic [CHAR_W-1:0]  sel_car;
  logic [PIX_W-1:0]   sel_adr;
  logic               blank_d;
  logic               data_d;

  logic [IdW-1:0]     last_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [ROM_AW-1:0]  rom_addr_q;
  tag_t               tag_q;
  tag_t               pipe_q [ROM_LATENCY];
  logic               data_q;
  logic               data_valid_q;
  logic [IdW-1:0]     data_id_q;

  rr_sel #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_sel (
    .req   (bus.Req),
    .last  (last_q),
    .gnt   (sel_gnt),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  always_comb begin
    sel_car = bus.Caracter[sel_idx*CHAR_W +: CHAR_W];
    sel_adr = bus.Address[sel_idx*PIX_W +: PIX_W];
`ifdef CHAR_ROM_ARB_BLANK_EN
    blank_d = (sel_car < BLANK_THRESH);
`else
    blank_d = 1'b0;
`endif
    data_d = bus.Rom_Q & ~pipe_q[ROM_LATENCY-1].blank;
  end

  // tag_q rides alongside Rom_Address; pipe_q covers the ROM read latency.
  always_ff @(posedge NCLK) begin
    if (RST) begin
      last_q       <= IdW'(NUM_REQ - 1);
      gnt_q        <= '0;
      rom_addr_q   <= '0;
      tag_q        <= '0;
      for (int unsigned k = 0; k < ROM_LATENCY; k++) pipe_q[k] <= '0;
      data_q       <= 1'b0;
      data_valid_q <= 1'b0;
      data_id_q    <= '0;
    end else begin
      gnt_q       <= sel_gnt;
      tag_q.valid <= sel_valid;
      tag_q.blank <= blank_d;
      tag_q.id    <= sel_idx;
      if (sel_valid) begin
        last_q     <= sel_idx;
        rom_addr_q <= {sel_car, sel_adr};
      end
      pipe_q[0] <= tag_q;
      for (int unsigned k = 1; k < ROM_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
      data_valid_q <= pipe_q[ROM_LATENCY-1].valid;
      if (pipe_q[ROM_LATENCY-1].valid) begin
        data_q    <= data_d;
        data_id_q <= pipe_q[ROM_LATENCY-1].id;
      end
    end
  end

  assign bus.Gnt         = gnt_q;
  assign bus.Rom_Address = rom_addr_q;
  assign bus.Data        = data_q;
  assign bus.Data_Valid  = data_valid_q;
  assign bus.Data_Id     = data_id_q;

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Directed and randomized bench for char_rom_arbiter against a behavioural
// model (rotating priority list plus a due-cycle table of pending results).
module tb_char_rom_arbiter;
  import char_rom_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned L = 1;

  logic NCLK = 1'b0;
  logic RST  = 1'b1;

  char_rom_arbiter_if #(.NUM_REQ(N)) bus ();

  char_rom_arbiter #(
    .NUM_REQ     (N),
    .ROM_LATENCY (L)
  ) dut (
    .NCLK (NCLK),
    .RST  (RST),
    .bus  (bus)
  );

  always #5 NCLK = ~NCLK;

  // Synchronous font ROM with one cycle of read latency.
  bit rom [0:8191];
  always @(posedge NCLK) bus.Rom_Q <= rom[bus.Rom_Address];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [N-1:0] m_gnt;
  int           m_last;
  logic [12:0]  m_addr;
  logic         m_data;
  logic         m_dv;
  logic [1:0]   m_id;
  bit           pv  [16];
  bit           pd  [16];
  int           pid [16];

  logic [6:0] car [N];
  logic [5:0] adr [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_pixel(input logic [12:0] a);
`ifdef CHAR_ROM_ARB_BLANK_EN
    if (a[12:6] < 7'h20) return 1'b0;
`endif
    return rom[a];
  endfunction

  task automatic step(input bit rst, input logic [N-1:0] req);
    int order[$];
    int s;
    int g;
    @(negedge NCLK);
    RST     = rst;
    bus.Req = req;
    for (int i = 0; i < N; i++) begin
      bus.Caracter[7*i +: 7] = car[i];
      bus.Address[6*i +: 6]  = adr[i];
    end
    @(posedge NCLK);
    cyc++;
    if (rst) begin
      m_gnt  = '0;
      m_last = N - 1;
      m_addr = '0;
      m_data = 1'b0;
      m_dv   = 1'b0;
      m_id   = '0;
      for (int i = 0; i < 16; i++) pv[i] = 1'b0;
    end else begin
      s    = cyc % 16;
      m_dv = pv[s];
      if (pv[s]) begin
        m_data = pd[s];
        m_id   = 2'(pid[s]);
        pv[s]  = 1'b0;
      end
      // Priority order for this cycle: the requester after the last winner first.
      for (int k = 1; k <= N; k++) order.push_back((m_last + k) % N);
      m_gnt = '0;
      g     = -1;
      foreach (order[j]) if (g < 0 && req[order[j]]) g = order[j];
      if (g >= 0) begin
        m_gnt[g] = 1'b1;
        m_last   = g;
        m_addr   = {car[g], adr[g]};
        s        = (cyc + L + 1) % 16;
        pv[s]    = 1'b1;
        pd[s]    = exp_pixel(m_addr);
        pid[s]   = g;
      end
    end
    #1;
    chk("gnt", 32'(bus.Gnt), 32'(m_gnt));
    chk("rom_address", 32'(bus.Rom_Address), 32'(m_addr));
    chk("data_valid", 32'(bus.Data_Valid), 32'(m_dv));
    chk("data", 32'(bus.Data), 32'(m_data));
    chk("data_id", 32'(bus.Data_Id), 32'(m_id));
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      car[i] = 7'($urandom);
      adr[i] = 6'($urandom);
    end
    bus.Req      = '0;
    bus.Caracter = '0;
    bus.Address  = '0;

    // Reset held two cycles with everyone requesting.
    step(1'b1, 4'b1111);
    chk("rst_gnt0", 32'(bus.Gnt), 32'd0);
    step(1'b1, 4'b1111);
    chk("rst_dv1", 32'(bus.Data_Valid), 32'd0);
    step(1'b0, 4'b1111);
    chk("first_gnt", 32'(bus.Gnt), 32'b0001);

    // Full rotation with no idle cycles.
    for (int i = 0; i < 7; i++) step(1'b0, 4'b1111);
    chk("rr_wrap", 32'(bus.Gnt), 32'b1000);

    // Latency and address packing.
    step(1'b1, 4'b0000);
    car[2] = 7'h41;
    adr[2] = 6'd9;
    step(1'b0, 4'b0100);
    chk("addr_1049", 32'(bus.Rom_Address), 32'h1049);
    step(1'b0, 4'b0000);
    chk("dv_early", 32'(bus.Data_Valid), 32'd0);
    step(1'b0, 4'b0000);
    chk("dv_lat", 32'(bus.Data_Valid), 32'd1);
    chk("id_lat", 32'(bus.Data_Id), 32'd2);
    chk("data_1049", 32'(bus.Data), 32'(rom[13'h1049]));

    // Wrap fairness from Last = 3.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1001);
    chk("fair0", 32'(bus.Gnt), 32'b0001);
    step(1'b0, 4'b1001);
    chk("fair3", 32'(bus.Gnt), 32'b1000);
    step(1'b0, 4'b1001);
    chk("fair0b", 32'(bus.Gnt), 32'b0001);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);
    chk("idle_dv", 32'(bus.Data_Valid), 32'd0);

    // Reset right after a grant discards the lookup.
    step(1'b0, 4'b0010);
    step(1'b1, 4'b0010);
    step(1'b0, 4'b0000);
    chk("flush_dv", 32'(bus.Data_Valid), 32'd0);
    step(1'b0, 4'b0000);

    // Control-code lookup with a lit ROM pixel.
    step(1'b1, 4'b0000);
    car[0] = 7'h0A;
    adr[0] = 6'd5;
    rom[{7'h0A, 6'd5}] = 1'b1;
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);
    chk("blank_dv", 32'(bus.Data_Valid), 32'd1);
`ifdef CHAR_ROM_ARB_BLANK_EN
    chk("blank_data", 32'(bus.Data), 32'd0);
`else
    chk("blank_data", 32'(bus.Data), 32'd1);
`endif

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        car[i] = 7'($urandom);
        adr[i] = 6'($urandom);
      end
      step(($urandom_range(0, 49) == 0), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
